// File: rtl/uart_tx_fifo_pkg.sv
// Shared CPU I/O definitions: UART transmitter state encoding and baud constants.
package uart_tx_fifo_pkg;

  localparam int unsigned SYS_CLK_HZ           = 100_000_000;
  localparam int unsigned BAUD_RATE            = 115_200;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = SYS_CLK_HZ / BAUD_RATE;
  localparam int unsigned BAUD_CNT_W           = 16;
  localparam int unsigned BIT_CNT_W            = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO, 2^DEPTH_LOG2 entries; push is ignored when full, pop when empty.
module byte_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign full    = count[DEPTH_LOG2];
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// CPU I/O UART transmitter: byte FIFO feeding an 8N1, LSB-first serializer with a registered tx line.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam logic [BAUD_CNT_W-1:0] BAUD_RELOAD = BAUD_CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e               state, state_nxt;
  logic [BAUD_CNT_W-1:0]   baud_cnt, baud_nxt;
  logic [BIT_CNT_W-1:0]    bit_cnt, bit_nxt;
  logic [7:0]              shreg, shreg_nxt;
  logic                    tx_nxt;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [7:0]              fifo_head;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  logic                    baud_done;
  logic                    launch;

  assign fifo_push = rdy_in && wr_en;
  assign full      = fifo_full;
  assign busy      = (fifo_count != '0) || (state != IDLE);
  assign baud_done = (baud_cnt == '0);

  byte_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
      tx       <= tx_nxt;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overflow <= 1'b0;
    end else if (rdy_in && wr_en && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  // IDLE and end-of-STOP share one launch path so back-to-back frames have no idle gap
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    tx_nxt    = tx;
    fifo_pop  = 1'b0;
    launch    = 1'b0;
    if (rdy_in) begin
      case (state)
        IDLE: begin
          launch = !fifo_empty;
        end
        START: begin
          if (baud_done) begin
            state_nxt = DATA;
            bit_nxt   = '0;
            tx_nxt    = shreg[0];
            baud_nxt  = BAUD_RELOAD;
          end else begin
            baud_nxt = baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_nxt = BAUD_RELOAD;
            if (bit_cnt == 3'd7) begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end else begin
              shreg_nxt = shreg >> 1;
              tx_nxt    = shreg[1];
              bit_nxt   = bit_cnt + 1'b1;
            end
          end else begin
            baud_nxt = baud_cnt - 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            if (fifo_empty) state_nxt = IDLE;
            else            launch    = 1'b1;
          end else begin
            baud_nxt = baud_cnt - 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (launch) begin
        fifo_pop  = 1'b1;
        shreg_nxt = fifo_head;
        baud_nxt  = BAUD_RELOAD;
        tx_nxt    = 1'b0;
        state_nxt = START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=4 with a frame-decoding scoreboard monitor.
module tb_uart_tx_fifo;

  logic       clk_in;
  logic       rst_in;
  logic       rdy_in;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       busy;
  logic       overflow;
  logic       tx;

  int         checks = 0;
  int         errors = 0;
  int         frames_ok = 0;
  logic [7:0] exp_q[$];
  logic       mon_abort = 1'b0;

  uart_tx_fifo #(
    .CLKS_PER_BIT    (4),
    .FIFO_DEPTH_LOG2 (3)
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected line level e cycles after the start edge of a 4-cycle-per-bit frame
  function automatic logic frame_bit(input logic [7:0] d, input int e);
    int k;
    k = e / 4;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag, input int maxc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < maxc) begin
      @(negedge clk_in);
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic pulse_reset();
    rst_in = 1'b1;
    @(negedge clk_in);
    check("reset_clears_overflow", overflow, 0);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  // advance n clock edges at which rdy_in was high, then land on the next falling edge
  task automatic wait_eff(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      do begin
        @(posedge clk_in);
        guard++;
      end while (!rdy_in && guard < 100);
    end
    @(negedge clk_in);
  endtask

  always @(posedge rst_in) mon_abort = 1'b1;

  initial begin : monitor
    logic [7:0] got;
    logic       start_lvl;
    logic       stop_lvl;
    forever begin
      @(negedge clk_in);
      if (tx === 1'b0 && rst_in === 1'b0) begin
        mon_abort = 1'b0;
        wait_eff(1);
        start_lvl = tx;
        for (int b = 0; b < 8; b++) begin
          wait_eff(4);
          got[b] = tx;
        end
        wait_eff(4);
        stop_lvl = tx;
        if (!mon_abort) begin
          check("mon_start_bit", start_lvl, 0);
          check("mon_stop_bit", stop_lvl, 1);
          check("mon_frame_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("mon_frame_data", got, exp_q.pop_front());
          frames_ok++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k;
    int s;
    int e;
    int bad;
    rst_in  = 1'b1;
    rdy_in  = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;

    repeat (3) @(negedge clk_in);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);

    // single byte from idle: exact per-cycle waveform
    wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
    @(negedge clk_in);
    wr_en = 1'b0;
    check("t1_tx_before_start", tx, 1);
    check("t1_busy_queued", busy, 1);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk_in);
      check($sformatf("t1_tx_c%0d", j), tx, frame_bit(8'h55, j));
    end
    @(negedge clk_in);
    check("t1_busy_fall", busy, 0);

    // three back-to-back frames
    repeat (2) @(negedge clk_in);
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h41 + i); exp_q.push_back(wr_data);
      @(negedge clk_in);
    end
    wr_en = 1'b0;
    k = 2;
    while (busy === 1'b1 && k < 400) begin
      @(negedge clk_in);
      k++;
      if (k == 40) check("t2_stop1_high", tx, 1);
      if (k == 41 || k == 81) check($sformatf("t2_no_gap_%0d", k), tx, 0);
    end
    check("t2_total_cycles", k, 121);

    // ten consecutive writes: ninth fills the FIFO, tenth is dropped
    repeat (2) @(negedge clk_in);
    wr_en = 1'b1; wr_data = 8'h10; exp_q.push_back(8'h10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      check($sformatf("t3_full_w%0d", i), full, (i >= 8));
      check($sformatf("t3_ovf_w%0d", i), overflow, (i >= 9));
      if (i < 9) begin
        wr_data = 8'(8'h11 + i);
        if (i + 1 < 9) exp_q.push_back(wr_data);
      end else begin
        wr_en = 1'b0;
      end
    end
    wait_idle("t3_drain", 600);
    check("t3_sb_empty", exp_q.size(), 0);
    check("t3_overflow_sticky", overflow, 1);
    pulse_reset();

    // write while full on the edge where STOP pops the next byte
    wr_en = 1'b1; wr_data = 8'h20; exp_q.push_back(8'h20);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_in);
      if (i < 8) begin
        wr_data = 8'(8'h21 + i);
        exp_q.push_back(wr_data);
      end else begin
        wr_en = 1'b0;
      end
    end
    repeat (32) @(negedge clk_in);
    check("t4_full_before_pop", full, 1);
    check("t4_ovf_before", overflow, 0);
    wr_en = 1'b1; wr_data = 8'hEE;
    @(negedge clk_in);
    wr_en = 1'b0;
    check("t4_overflow", overflow, 1);
    check("t4_next_start", tx, 0);
    wait_idle("t4_drain", 600);
    check("t4_sb_empty", exp_q.size(), 0);
    pulse_reset();

    // reset mid-DATA of 0xA5 with two bytes queued behind it
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = (i == 0) ? 8'hA5 : 8'(i);
      @(negedge clk_in);
    end
    wr_en = 1'b0;
    repeat (8) @(negedge clk_in);
    check("t5_tx_bit1_low", tx, 0);
    rst_in = 1'b1;
    #1;
    check("t5_async_tx", tx, 1);
    check("t5_async_busy", busy, 0);
    check("t5_async_full", full, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk_in);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("t5_silent_after_reset", bad, 0);

    // rdy_in low for 7 cycles during bit 3 of 0x0F; a write in that window is ignored
    wr_en = 1'b1; wr_data = 8'h0F; exp_q.push_back(8'h0F);
    @(negedge clk_in);
    wr_en = 1'b0;
    for (int m = 1; m <= 47; m++) begin
      @(negedge clk_in);
      s = m - 18;
      if (s < 0) s = 0;
      if (s > 7) s = 7;
      e = (m - 1) - s;
      check($sformatf("t6_tx_c%0d", m), tx, frame_bit(8'h0F, e));
      if (m == 18) rdy_in = 1'b0;
      if (m == 20) begin wr_en = 1'b1; wr_data = 8'h77; end
      if (m == 21) wr_en = 1'b0;
      if (m == 25) rdy_in = 1'b1;
    end
    @(negedge clk_in);
    check("t6_busy_fall", busy, 0);
    check("t6_no_overflow", overflow, 0);

    repeat (10) @(negedge clk_in);
    check("final_sb_empty", exp_q.size(), 0);
    check("final_frame_count", frames_ok, 23);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
